pattern_sweep_capture: RTL and testbench

Exhaustive-stimulus sequencer and response checker for a single-output combinational or sequential circuit under test in the trojan-detection flow. It drives every one of the 2^NIN input patterns in ascending order and waits a programmable settle time per pattern. It samples the circuit's single-bit response into a truth-table vector and compares that vector bit-by-bit against a golden table, flagging the first divergent pattern. It both feeds the circuit under test and consumes its response, replacing the file-dump capture path with an on-chip verdict.

---
 rtl/pattern_sweep_pkg.sv | 22 ++
 rtl/sweep_settle_timer.sv | 37 +++
 rtl/pattern_sweep_capture.sv | 137 +++++++++++++
 tb/tb_pattern_sweep_capture.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_sweep_pkg.sv
// Shared types and sizing helpers for the exhaustive pattern sweep checker.
package pattern_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

    localparam int DEF_NIN  = 4;
    localparam int DEF_PATS = 1 << DEF_NIN;

    function automatic int pattern_count(input int nin);
        return 1 << nin;
    endfunction

    function automatic int settle_width(input int settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter; last_o flags the final settle cycle of a pattern.
module sweep_settle_timer
    import pattern_sweep_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int W      = settle_width(SETTLE)
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic en_i,
    output logic last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(SETTLE);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/pattern_sweep_capture.sv
// Drives all 2^NIN patterns, captures the single-bit response into a truth
// table and reports the lowest pattern whose response differs from golden.
module pattern_sweep_capture
    import pattern_sweep_pkg::*;
#(
    parameter int NIN    = 4,
    parameter int SETTLE = 1
) (
    input  logic                      CK,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [(1 << NIN)-1:0]     golden,
    output logic [NIN-1:0]            N,
    input  logic                      dut_out,
    output logic                      busy,
    output logic                      done,
    output logic [(1 << NIN)-1:0]     truth,
    output logic                      mismatch,
    output logic [NIN-1:0]            first_fail
);

    localparam int PATS = pattern_count(NIN);

    sweep_state_e      state_q, state_d;
    logic [NIN-1:0]    n_q, n_d;
    logic [PATS-1:0]   golden_q, golden_d;
    logic [PATS-1:0]   truth_q, truth_d;
    logic              mismatch_q, mismatch_d;
    logic [NIN-1:0]    first_fail_q, first_fail_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              timer_load;
    logic              timer_en;
    logic              timer_last;
    logic              last_pattern;

    assign last_pattern = &n_q;

    // Reload on sweep start and whenever another pattern follows a sample.
    assign timer_load = ((state_q == IDLE) && start) ||
                        ((state_q == SAMPLE) && !last_pattern);
    assign timer_en   = (state_q == APPLY);

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk_i   (CK),
        .rst_n_i (reset_n),
        .load_i  (timer_load),
        .en_i    (timer_en),
        .last_o  (timer_last)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        golden_d     = golden_q;
        truth_d      = truth_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    golden_d     = golden;
                    truth_d      = '0;
                    mismatch_d   = 1'b0;
                    first_fail_d = '0;
                    n_d          = '0;
                    busy_d       = 1'b1;
                    state_d      = APPLY;
                end
            end
            APPLY: begin
                if (timer_last) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                truth_d[n_q] = dut_out;
                // Patterns ascend, so the first recorded failure is the lowest.
                if ((dut_out != golden_q[n_q]) && !mismatch_q) begin
                    mismatch_d   = 1'b1;
                    first_fail_d = n_q;
                end
                if (last_pattern) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    n_d     = n_q + NIN'(1);
                    state_d = APPLY;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                n_d     = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            golden_q     <= '0;
            truth_q      <= '0;
            mismatch_q   <= 1'b0;
            first_fail_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            golden_q     <= golden_d;
            truth_q      <= truth_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign N          = n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign truth      = truth_q;
    assign mismatch   = mismatch_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_pattern_sweep_capture.sv
// Scoreboard bench: two sweepers (SETTLE=1 and SETTLE=3) feeding modelled circuits.
module tb_pattern_sweep_capture;

    typedef struct {
        logic [15:0] truth;
        logic        mm;
        logic [3:0]  ff;
        int          dcyc;
    } exp_t;

    logic        CK = 1'b0;
    logic        reset_n;
    logic        start1, start3;
    logic [15:0] golden1, golden3;
    logic [3:0]  N1, N3;
    logic        dout1, dout3;
    logic        busy1, busy3, done1, done3;
    logic [15:0] truth1, truth3;
    logic        mismatch1, mismatch3;
    logic [3:0]  ff1, ff3;

    int   mode1 = 0;
    int   mode3 = 0;
    logic [3:0] c1 [3];
    logic [3:0] c3 [3];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   d1cnt = 0;
    int   d3cnt = 0;
    exp_t q1 [$];
    exp_t q3 [$];

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    pattern_sweep_capture #(.NIN(4), .SETTLE(1)) dut1 (
        .CK(CK), .reset_n(reset_n), .start(start1), .golden(golden1), .N(N1),
        .dut_out(dout1), .busy(busy1), .done(done1), .truth(truth1),
        .mismatch(mismatch1), .first_fail(ff1)
    );

    pattern_sweep_capture #(.NIN(4), .SETTLE(3)) dut3 (
        .CK(CK), .reset_n(reset_n), .start(start3), .golden(golden3), .N(N3),
        .dut_out(dout3), .busy(busy3), .done(done3), .truth(truth3),
        .mismatch(mismatch3), .first_fail(ff3)
    );

    // Circuit under test: 0 = 4-input AND, 1 = AND with trojan at 10 and 12,
    // 2 = parity whose output lags its input by three clocks.
    function automatic logic circ(input int m, input logic [3:0] p);
        case (m)
            0:       return (p == 4'hF);
            1:       return (p == 4'hF) || (p == 4'hA) || (p == 4'hC);
            default: return ^p;
        endcase
    endfunction

    always @(posedge CK) begin
        c1[0] <= N1; c1[1] <= c1[0]; c1[2] <= c1[1];
        c3[0] <= N3; c3[1] <= c3[0]; c3[2] <= c3[1];
    end

    always_comb begin
        dout1 = (mode1 == 2) ? circ(2, c1[2]) : circ(mode1, N1);
        dout3 = (mode3 == 2) ? circ(2, c3[2]) : circ(mode3, N3);
    end

    // Pattern i is sampled at start edge + (i+1)*(S+1); a circuit with L clocks
    // of latency shows the pattern applied L+1 cycles before that edge.
    function automatic exp_t model(input int m, input logic [15:0] g, input int s, input int k);
        exp_t e;
        int   lat, off, p;
        lat    = (m == 2) ? 3 : 0;
        e.mm   = 1'b0;
        e.ff   = 4'd0;
        e.truth = '0;
        for (int i = 0; i < 16; i++) begin
            off = (i + 1) * (s + 1) - 1 - lat;
            p   = (off < 0) ? 0 : off / (s + 1);
            e.truth[i] = circ(m, 4'(p));
        end
        for (int i = 15; i >= 0; i--) begin
            if (e.truth[i] != g[i]) begin
                e.mm = 1'b1;
                e.ff = 4'(i);
            end
        end
        e.dcyc = k + 16 * (s + 1);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input string tag, input logic [15:0] tr, input logic mm,
                       input logic [3:0] ff, input logic bsy, inout exp_t q [$]);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_done: got done=1 expected no done", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_truth"}, 32'(tr), 32'(e.truth));
            chk({tag, "_mismatch"}, 32'(mm), 32'(e.mm));
            if (e.mm) chk({tag, "_first_fail"}, 32'(ff), 32'(e.ff));
            chk({tag, "_done_cycle"}, 32'(cyc), 32'(e.dcyc));
            chk({tag, "_busy_at_done"}, 32'(bsy), 32'd1);
            $display("%s sweep done cyc=%0d truth=%h mismatch=%0d first_fail=%0d",
                     tag, cyc, tr, mm, ff);
        end
    endtask

    always @(negedge CK) begin
        if (reset_n && done1) begin
            d1cnt++;
            mon("s1", truth1, mismatch1, ff1, busy1, q1);
        end
        if (reset_n && done3) begin
            d3cnt++;
            mon("s3", truth3, mismatch3, ff3, busy3, q3);
        end
    end

    task automatic run_sweep(input int sel, input int m, input logic [15:0] g);
        int k;
        repeat (4) @(negedge CK);
        if (sel == 1) begin mode1 = m; golden1 = g; start1 = 1'b1; end
        else          begin mode3 = m; golden3 = g; start3 = 1'b1; end
        @(posedge CK);
        #1;
        k = cyc;
        start1 = 1'b0;
        start3 = 1'b0;
        if (sel == 1) q1.push_back(model(m, g, 1, k));
        else          q3.push_back(model(m, g, 3, k));
    endtask

    task automatic wait_done(input int sel, input int prev);
        bit seen = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge CK);
            if (((sel == 1) ? d1cnt : d3cnt) > prev) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout_s%0d: got no done expected done", sel);
        end
    endtask

    task automatic wait_n1(input logic [3:0] v);
        bit seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge CK);
            if (N1 == v) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_N_%0d: got N=%0d expected N=%0d", v, N1, v);
        end
    endtask

    initial begin
        int p;
        reset_n = 1'b0;
        start1  = 1'b1;
        start3  = 1'b1;
        golden1 = 16'h8000;
        golden3 = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            c1[i] = '0;
            c3[i] = '0;
        end

        repeat (3) @(negedge CK);
        chk("reset_N", 32'(N1), 0);
        chk("reset_busy", 32'(busy1), 0);
        chk("reset_done", 32'(done1), 0);
        chk("reset_truth", 32'(truth1), 0);
        chk("reset_mismatch", 32'(mismatch1), 0);
        chk("reset_first_fail", 32'(ff1), 0);
        chk("reset_busy_s3", 32'(busy3), 0);
        start1  = 1'b0;
        start3  = 1'b0;
        reset_n = 1'b1;
        @(negedge CK);
        chk("idle_after_reset_busy", 32'(busy1), 0);

        // Clean match with a pattern-by-pattern check of N.
        p = d1cnt;
        run_sweep(1, 0, 16'h8000);
        @(negedge CK);
        chk("start_busy", 32'(busy1), 1);
        chk("start_N", 32'(N1), 0);
        for (int c = 1; c < 32; c++) begin
            @(negedge CK);
            chk($sformatf("s1_N_off%0d", c), 32'(N1), 32'(c / 2));
        end
        wait_done(1, p);

        // Trojan injection.
        p = d1cnt;
        run_sweep(1, 1, 16'h8000);
        wait_done(1, p);

        // Restart request and golden change during a sweep are ignored.
        p = d1cnt;
        run_sweep(1, 0, 16'h8000);
        wait_n1(4'd5);
        start1 = 1'b1;
        @(negedge CK);
        start1 = 1'b0;
        wait_n1(4'd7);
        golden1 = 16'hFFFF;
        wait_done(1, p);
        repeat (40) @(negedge CK);
        chk("single_done", 32'(d1cnt), 32'(p + 1));
        golden1 = 16'h8000;

        // Reset mid-sweep: slow parity circuit yields a mismatch before pattern 9.
        run_sweep(1, 2, 16'h6996);
        wait_n1(4'd9);
        chk("pre_reset_mismatch", 32'(mismatch1), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_N", 32'(N1), 0);
        chk("midreset_truth", 32'(truth1), 0);
        chk("midreset_busy", 32'(busy1), 0);
        chk("midreset_mismatch", 32'(mismatch1), 0);
        void'(q1.pop_back());
        repeat (2) @(negedge CK);
        reset_n = 1'b1;
        p = d1cnt;
        run_sweep(1, 1, 16'h8000);
        wait_done(1, p);

        // Slow circuit, SETTLE=1: stale responses must be flagged.
        p = d1cnt;
        run_sweep(1, 2, 16'h6996);
        wait_done(1, p);

        // Slow circuit, SETTLE=3: each pattern held 4 cycles, clean verdict.
        p = d3cnt;
        run_sweep(3, 2, 16'h6996);
        for (int c = 0; c < 64; c++) begin
            @(negedge CK);
            chk($sformatf("s3_N_off%0d", c), 32'(N3), 32'(c / 4));
        end
        wait_done(3, p);

        repeat (5) @(negedge CK);
        chk("s1_queue_empty", 32'(q1.size()), 0);
        chk("s3_queue_empty", 32'(q3.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
